// File: rtl/dvp_raw_tx.sv
// dvp_raw_tx: DVP RAW8 camera emulator generating PCLK, VSYNC, HREF and test-pattern pixels
module dvp_raw_tx #(
  parameter int IMG_W       = 512,
  parameter int IMG_H       = 512,
  parameter int H_BLANK     = 64,
  parameter int VSYNC_LINES = 4,
  parameter int V_FP        = 8,
  parameter int V_BP        = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [1:0]  pattern,
  output logic        dvp_pclk,
  output logic        dvp_vsync,
  output logic        dvp_href,
  output logic [7:0]  dvp_data,
  output logic        frame_done,
  output logic [15:0] frame_count
);
  localparam int LINE_LEN = IMG_W + H_BLANK;
  localparam int PW = $clog2(LINE_LEN);
  localparam int M1 = VSYNC_LINES > V_FP ? VSYNC_LINES : V_FP;
  localparam int M2 = IMG_H > V_BP ? IMG_H : V_BP;
  localparam int LMAX = M1 > M2 ? M1 : M2;
  localparam int LW = LMAX > 1 ? $clog2(LMAX) : 1;
  localparam int YW = IMG_H > 1 ? $clog2(IMG_H) : 1;
  localparam logic [PW-1:0] PIX_LAST = PW'(LINE_LEN - 1);
  localparam logic [PW-1:0] PIX_ACT  = PW'(IMG_W);
  localparam logic [LW-1:0] VS_LAST  = LW'(VSYNC_LINES - 1);
  localparam logic [LW-1:0] FP_LAST  = LW'(V_FP - 1);
  localparam logic [LW-1:0] H_LAST   = LW'(IMG_H - 1);
  localparam logic [LW-1:0] BP_LAST  = LW'(V_BP - 1);
  typedef enum logic [2:0] {IDLE, VSYNC, VFP, ACTIVE, VBP} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] pix_q, pix_d;
  logic [LW-1:0] line_q, line_d, line_last;
  logic [YW-1:0] y_q, y_d;
  logic [1:0] pat_q, pat_d;
  logic [15:0] fc_q, fc_d;
  logic pclk_q, vsync_q, vsync_d, href_q, href_d, done_q, done_d;
  logic [7:0] data_q, data_d, x8, bayer, pix_val;
  logic line_end, last_line, frame_end, y0, y2;
  // Everything advances only on the clk edge where pclk_q falls (pclk_q == 1 before the edge)
  always_comb begin
    state_d = state_q;
    pix_d = pix_q;
    line_d = line_q;
    y_d = y_q;
    pat_d = pat_q;
    fc_d = fc_q;
    vsync_d = vsync_q;
    href_d = href_q;
    data_d = data_q;
    done_d = 1'b0;
    line_end = pix_q == PIX_LAST;
    line_last = state_q == VSYNC ? VS_LAST : state_q == VFP ? FP_LAST : state_q == ACTIVE ? H_LAST : BP_LAST;
    last_line = line_end && line_q == line_last;
    frame_end = last_line && (state_q == VBP || (state_q == ACTIVE && V_BP == 0));
    if (pclk_q) begin
      pix_d = (state_q == IDLE || line_end) ? '0 : pix_q + 1'b1;
      line_d = last_line ? '0 : line_end ? line_q + 1'b1 : line_q;
      case (state_q)
        IDLE:    state_d = enable ? VSYNC : IDLE;
        VSYNC:   state_d = last_line ? (V_FP > 0 ? VFP : ACTIVE) : VSYNC;
        VFP:     state_d = last_line ? ACTIVE : VFP;
        ACTIVE:  state_d = (last_line && V_BP > 0) ? VBP : ACTIVE;
        default: state_d = VBP;
      endcase
      if (frame_end) begin
        state_d = enable ? VSYNC : IDLE;
        done_d = 1'b1;
        fc_d = fc_q + 1'b1;
      end
      pat_d = (state_d == VSYNC && state_q != VSYNC) ? pattern : pat_q;
      y_d = state_d != ACTIVE ? '0 : (state_q == ACTIVE && line_end) ? y_q + 1'b1 : y_q;
    end
    x8 = 8'(pix_d);
    y0 = y_d[0];
    y2 = |(8'(y_d) & 8'h04);
    bayer = (y0 ? 8'h80 : 8'hC0) - (x8[0] ? 8'h40 : 8'h00);
    pix_val = pat_d == 2'd0 ? bayer : pat_d == 2'd1 ? x8 : pat_d == 2'd2 ? {8{x8[2] ^ y2}} : fc_q[7:0] + x8;
    if (pclk_q) begin
      vsync_d = state_d == VSYNC;
      href_d = state_d == ACTIVE && pix_d < PIX_ACT;
      data_d = href_d ? pix_val : 8'h00;
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      pix_q <= '0;
      line_q <= '0;
      y_q <= '0;
      pat_q <= '0;
      fc_q <= '0;
      pclk_q <= 1'b0;
      vsync_q <= 1'b0;
      href_q <= 1'b0;
      data_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pix_q <= pix_d;
      line_q <= line_d;
      y_q <= y_d;
      pat_q <= pat_d;
      fc_q <= fc_d;
      pclk_q <= ~pclk_q;
      vsync_q <= vsync_d;
      href_q <= href_d;
      data_q <= data_d;
      done_q <= done_d;
    end
  assign dvp_pclk = pclk_q;
  assign dvp_vsync = vsync_q;
  assign dvp_href = href_q;
  assign dvp_data = data_q;
  assign frame_done = done_q;
  assign frame_count = fc_q;
endmodule

// File: tb/tb_dvp_raw_tx.sv
// tb_dvp_raw_tx: scoreboard bench; expected per-PCLK frames are queued and a monitor compares them
module tb_dvp_raw_tx;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;
  logic [1:0] pattern = 2'd0;
  logic dvp_pclk, dvp_vsync, dvp_href, frame_done;
  logic [7:0] dvp_data;
  logic [15:0] frame_count;
  int total = 0;
  int passed = 0;
  typedef struct {logic vs; logic hr; logic [7:0] d; bit last;} exp_t;
  exp_t sb[$];
  exp_t mon_e;
  bit in_frame = 1'b0;
  bit expect_done = 1'b0;
  logic [15:0] exp_fc = 16'd0;
  always #5 clk = ~clk;
  dvp_raw_tx #(.IMG_W(8), .IMG_H(4), .H_BLANK(4), .VSYNC_LINES(1), .V_FP(1), .V_BP(1)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .pattern(pattern),
    .dvp_pclk(dvp_pclk), .dvp_vsync(dvp_vsync), .dvp_href(dvp_href), .dvp_data(dvp_data),
    .frame_done(frame_done), .frame_count(frame_count)
  );
  task automatic chk(input bit ok, input string name, input int act, input int req);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
  endtask
  function automatic logic [7:0] exp_pix(input int pat, input int x, input int y, input int fc);
    case (pat)
      0: return ((y % 2) == 0) ? (((x % 2) == 0) ? 8'hC0 : 8'h80) : (((x % 2) == 0) ? 8'h80 : 8'h40);
      1: return 8'(x);
      2: return (((x / 4) % 2) != ((y / 4) % 2)) ? 8'hFF : 8'h00;
      default: return 8'((fc + x) % 256);
    endcase
  endfunction
  // One frame: line 0 VSYNC, line 1 front porch, lines 2..5 active, line 6 back porch; 12 PCLK each
  task automatic push_frame(input int pat, input int fc);
    exp_t e;
    for (int l = 0; l < 7; l++)
      for (int p = 0; p < 12; p++) begin
        e.vs = (l == 0);
        e.hr = (l >= 2 && l < 6 && p < 8);
        e.d = e.hr ? exp_pix(pat, p, l - 2, fc) : 8'h00;
        e.last = (l == 6 && p == 11);
        sb.push_back(e);
      end
  endtask
  task automatic wait_sig(input int which, input int max_clk, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < max_clk && !seen; i++) begin
      @(posedge clk);
      #1;
      seen = which == 0 ? dvp_vsync : which == 1 ? dvp_href : frame_done;
    end
    chk(seen, name, int'(seen), 1);
  endtask
  // Monitor: second half of each PCLK samples the bus; first half checks the frame_done pulse
  always @(negedge clk) begin
    if (!reset_n) begin
      sb.delete();
      in_frame = 1'b0;
      expect_done = 1'b0;
      exp_fc = 16'd0;
    end else if (dvp_pclk) begin
      chk(frame_done == 1'b0, "done_width", int'(frame_done), 0);
      if (in_frame || (sb.size() > 0 && dvp_vsync)) begin
        if (sb.size() == 0) begin
          chk(1'b0, "sb_underflow", 0, 1);
          in_frame = 1'b0;
        end else begin
          mon_e = sb.pop_front();
          chk({dvp_vsync, dvp_href, dvp_data} === {mon_e.vs, mon_e.hr, mon_e.d}, "pclk_out",
              int'({dvp_vsync, dvp_href, dvp_data}), int'({mon_e.vs, mon_e.hr, mon_e.d}));
          in_frame = !mon_e.last;
          expect_done = mon_e.last;
        end
      end else
        chk({dvp_vsync, dvp_href, dvp_data} === 10'd0, "idle_bus", int'({dvp_vsync, dvp_href, dvp_data}), 0);
    end else if (expect_done) begin
      chk(frame_done === 1'b1, "frame_done", int'(frame_done), 1);
      chk(frame_count === exp_fc + 16'd1, "frame_count", int'(frame_count), int'(exp_fc + 16'd1));
      exp_fc = exp_fc + 16'd1;
      expect_done = 1'b0;
    end else
      chk(frame_done == 1'b0, "done_spurious", int'(frame_done), 0);
  end
  initial begin
    int bad_pclk, bad_out;
    logic prev;
    repeat (3) @(posedge clk);
    #1;
    chk({dvp_pclk, dvp_vsync, dvp_href, dvp_data, frame_done, frame_count} === 28'd0, "reset_state",
        int'({dvp_pclk, dvp_vsync, dvp_href, dvp_data, frame_done, frame_count}), 0);
    @(negedge clk);
    reset_n = 1'b1;
    bad_pclk = 0;
    bad_out = 0;
    prev = dvp_pclk;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (dvp_pclk === prev) bad_pclk++;
      if ({dvp_vsync, dvp_href, dvp_data, frame_count} !== 26'd0) bad_out++;
      prev = dvp_pclk;
    end
    chk(bad_pclk == 0, "idle_pclk_toggle", bad_pclk, 0);
    chk(bad_out == 0, "idle_outputs_low", bad_out, 0);
    // Back-to-back frames: checker, then fc+x (pattern switched mid-active), then Bayer
    pattern = 2'd2;
    push_frame(2, 0);
    push_frame(3, 1);
    push_frame(0, 2);
    @(negedge clk);
    enable = 1'b1;
    wait_sig(0, 2, "enable_latency");
    wait_sig(1, 400, "f0_href");
    pattern = 2'd3;
    wait_sig(2, 400, "f0_done");
    pattern = 2'd0;
    wait_sig(2, 400, "f1_done");
    wait_sig(1, 400, "f2_href");
    enable = 1'b0;
    wait_sig(2, 400, "f2_done");
    chk(frame_count === 16'd3, "count_after_stop", int'(frame_count), 3);
    repeat (300) @(posedge clk);
    chk(sb.size() == 0, "sb_drained", sb.size(), 0);
    pattern = 2'd1;
    push_frame(1, 3);
    @(negedge clk);
    enable = 1'b1;
    wait_sig(0, 2, "reenable_latency");
    wait_sig(1, 400, "f3_href");
    repeat (6) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk({dvp_vsync, dvp_href, dvp_data, frame_count} === 26'd0, "midline_reset",
        int'({dvp_vsync, dvp_href, dvp_data, frame_count}), 0);
    @(negedge clk);
    @(negedge clk);
    #1;
    reset_n = 1'b1;
    push_frame(1, 0);
    wait_sig(1, 400, "post_reset_href");
    enable = 1'b0;
    wait_sig(2, 400, "post_reset_done");
    chk(frame_count === 16'd1, "post_reset_count", int'(frame_count), 1);
    repeat (100) @(posedge clk);
    chk(sb.size() == 0, "sb_final_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
